// File: rtl/ureg_rtq_pkg.sv
// ureg_rtq_pkg: shared address constants, read-back indices and dispatcher states
package ureg_rtq_pkg;
  localparam logic [7:0] UREG_WAIT = 8'h80;
  localparam logic [7:0] UREG_CASE = 8'h81;
  localparam logic [7:0] UREG_SYNC = 8'h82;
  localparam logic [2:0] RB_STATUS = 3'd0;
  localparam logic [2:0] RB_CYCLE  = 3'd1;
  localparam logic [2:0] RB_DISP   = 3'd2;
  localparam logic [2:0] RB_ERR    = 3'd3;
  localparam logic [2:0] RB_JMP    = 3'd4;
  localparam int ENTRY_W = 40;
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
endpackage

// File: rtl/ureg_fifo.sv
// ureg_fifo: synchronous first-word-fall-through FIFO with occupancy level
module ureg_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 40
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge i_clk) if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/ureg_rtq.sv
// ureg_rtq: timestamped user-register queue dispatching writes to real-time channels
module ureg_rtq import ureg_rtq_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ureg_we,
  input  logic [7:0]  i_ureg_waddr,
  input  logic [31:0] i_ureg_wdata,
  input  logic [2:0]  i_ureg_raddr,
  output logic [31:0] o_ureg_rdata,
  output logic        o_hlt,
  input  logic [7:0]  i_case_sel,
  output logic [31:0] o_jmp_offset,
  output logic        o_rt_valid,
  output logic [6:0]  o_rt_addr,
  output logic [31:0] o_rt_data
);
  localparam int LW = $clog2(DEPTH) + 1;
  state_t state, state_n;
  logic [31:0] cnt, cnt_n, cyc_cnt, disp_cnt, err_cnt, status;
  logic [LW-1:0] level;
  logic [ENTRY_W-1:0] dout;
  logic full, empty, is_push, is_sync, acc, push, pop, pop_data, busy;
  assign is_push = !i_ureg_waddr[7] || i_ureg_waddr == UREG_WAIT;
  assign is_sync = i_ureg_waddr == UREG_SYNC;
  assign o_hlt = !i_rst && i_ureg_we && ((is_push && full) || (is_sync && (!empty || state != S_IDLE)));
  assign acc = !i_rst && i_ureg_we && !o_hlt;
  assign push = acc && is_push;
  assign pop = state == S_IDLE && !empty;
  // only 0x80 entries carry bit 39, so it marks a wait entry
  assign pop_data = pop && !dout[39];
  ureg_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .push(push), .pop(pop),
    .din({i_ureg_waddr, i_ureg_wdata}), .dout(dout),
    .full(full), .empty(empty), .level(level)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == S_WAIT) begin
      cnt_n = cnt - 32'd1;
      state_n = cnt == 32'd1 ? S_IDLE : S_WAIT;
    end else if (pop && dout[39] && dout[31:0] != 32'd0) begin
      cnt_n = dout[31:0];
      state_n = S_WAIT;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt <= '0;
      cyc_cnt <= '0;
      disp_cnt <= '0;
      err_cnt <= '0;
      o_jmp_offset <= '0;
      o_rt_valid <= 1'b0;
      o_rt_addr <= '0;
      o_rt_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cyc_cnt <= cyc_cnt + 32'd1;
      o_rt_valid <= pop_data;
      if (pop_data) begin
        o_rt_addr <= dout[38:32];
        o_rt_data <= dout[31:0];
        disp_cnt <= disp_cnt + 32'd1;
      end
      if (acc && i_ureg_waddr == UREG_CASE) o_jmp_offset <= {22'b0, i_case_sel, 2'b00};
      if (acc && i_ureg_waddr > UREG_SYNC) err_cnt <= err_cnt + 32'd1;
    end
  end
  assign busy = !empty || state == S_WAIT;
  assign status = {16'b0, 8'(level), 4'b0, busy, full, empty, state};
  assign o_ureg_rdata = i_ureg_raddr == RB_STATUS ? status :
                        i_ureg_raddr == RB_CYCLE  ? cyc_cnt :
                        i_ureg_raddr == RB_DISP   ? disp_cnt :
                        i_ureg_raddr == RB_ERR    ? err_cnt :
                        i_ureg_raddr == RB_JMP    ? o_jmp_offset : 32'd0;
endmodule

// File: tb/tb_ureg_rtq.sv
// tb_ureg_rtq: scenario tasks driving ureg_rtq against a time-based queue model
module tb_ureg_rtq;
  localparam int DEPTH = 16;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1, we = 1'b0;
  logic [7:0] waddr = 8'h0, case_sel = 8'h0;
  logic [31:0] wdata = 32'h0;
  logic [2:0] raddr = 3'd0;
  logic [31:0] rdata, jmp, rt_data;
  logic hlt, rt_valid;
  logic [6:0] rt_addr;
  always #5 i_clk = ~i_clk;
  ureg_rtq #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ureg_we(we), .i_ureg_waddr(waddr),
    .i_ureg_wdata(wdata), .i_ureg_raddr(raddr), .o_ureg_rdata(rdata),
    .o_hlt(hlt), .i_case_sel(case_sel), .o_jmp_offset(jmp),
    .o_rt_valid(rt_valid), .o_rt_addr(rt_addr), .o_rt_data(rt_data)
  );
  int checks = 0, errors = 0;
  bit armed = 0, acc = 0;
  logic [39:0] q[$];
  longint t = 0, ready = 0;
  logic [31:0] m_cyc = 0, m_disp = 0, m_err = 0, m_jmp = 0, ed = 0;
  logic ev = 0;
  logic [6:0] ea = 0;
  int obs_t[$];
  logic [6:0] obs_a[$];
  logic [31:0] obs_d[$];
  // Model: an entry may be popped once the current cycle reaches `ready`;
  // a data pop makes the next cycle ready, a wait(N) pop delays it by N more.
  task automatic step();
    logic idle, pt, eh;
    logic [31:0] er;
    logic [39:0] e;
    @(negedge i_clk);
    idle = t >= ready;
    pt = !waddr[7] || waddr == 8'h80;
    eh = !i_rst && we && ((pt && q.size() == DEPTH) || (waddr == 8'h82 && (q.size() != 0 || !idle)));
    case (raddr)
      3'd0: er = {16'b0, 8'(q.size()), 4'b0, (q.size() != 0 || !idle), (q.size() == DEPTH), (q.size() == 0), !idle};
      3'd1: er = m_cyc;
      3'd2: er = m_disp;
      3'd3: er = m_err;
      3'd4: er = m_jmp;
      default: er = 32'd0;
    endcase
    if (armed) begin
      checks += 6;
      if (hlt !== eh) begin errors++; $display("FAIL hlt t=%0d got %b exp %b", t, hlt, eh); end
      if (rt_valid !== ev) begin errors++; $display("FAIL rt_valid t=%0d got %b exp %b", t, rt_valid, ev); end
      if (rt_addr !== ea) begin errors++; $display("FAIL rt_addr t=%0d got %h exp %h", t, rt_addr, ea); end
      if (rt_data !== ed) begin errors++; $display("FAIL rt_data t=%0d got %h exp %h", t, rt_data, ed); end
      if (jmp !== m_jmp) begin errors++; $display("FAIL jmp_offset t=%0d got %h exp %h", t, jmp, m_jmp); end
      if (rdata !== er) begin errors++; $display("FAIL rdata[%0d] t=%0d got %h exp %h", raddr, t, rdata, er); end
    end
    if (rt_valid === 1'b1) begin obs_t.push_back(int'(t)); obs_a.push_back(rt_addr); obs_d.push_back(rt_data); end
    acc = we && !eh && !i_rst;
    ev = 0;
    if (i_rst) begin
      q.delete(); ready = t + 1; m_cyc = 0; m_disp = 0; m_err = 0; m_jmp = 0; ea = 0; ed = 0;
    end else begin
      if (idle && q.size() > 0) begin
        e = q.pop_front();
        if (!e[39]) begin ev = 1; ea = e[38:32]; ed = e[31:0]; m_disp++; ready = t + 1; end
        else ready = t + 1 + longint'(e[31:0]);
      end
      if (acc) begin
        if (pt) q.push_back({waddr, wdata});
        else if (waddr == 8'h81) m_jmp = {22'b0, case_sel, 2'b00};
        else if (waddr != 8'h82) m_err++;
      end
      m_cyc++;
    end
    t++;
    @(posedge i_clk);
    #1;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin raddr = 3'($urandom_range(0, 7)); step(); end
  endtask
  task automatic write(input logic [7:0] a, input logic [31:0] d, output int stalls);
    we = 1; waddr = a; wdata = d; stalls = 0; acc = 0;
    for (int i = 0; i < 5000 && !acc; i++) begin step(); if (!acc) stalls++; end
    checks++;
    if (!acc) begin errors++; $display("FAIL write_timeout addr %h got stalled exp accepted", a); end
    we = 0; waddr = 0; wdata = 0;
  endtask
  task automatic do_reset();
    i_rst = 1; step(); armed = 1; step(); i_rst = 0;
    obs_t.delete(); obs_a.delete(); obs_d.delete();
  endtask
  task automatic test_reset();
    we = 1; waddr = 8'h05; wdata = 32'h1234;
    do_reset();
    we = 0;
    raddr = 0; #1;
    checks += 5;
    if (rdata !== 32'h2) begin errors++; $display("FAIL reset_status got %h exp %h", rdata, 32'h2); end
    if (rt_valid !== 1'b0 || rt_addr !== 7'd0 || rt_data !== 32'd0) begin errors++; $display("FAIL reset_rt got %b/%h/%h exp 0", rt_valid, rt_addr, rt_data); end
    if (jmp !== 32'd0) begin errors++; $display("FAIL reset_jmp got %h exp 0", jmp); end
    if (hlt !== 1'b0) begin errors++; $display("FAIL reset_hlt got %b exp 0", hlt); end
    raddr = 1; #1;
    if (rdata !== 32'd0) begin errors++; $display("FAIL reset_cycle got %h exp 0", rdata); end
    run(4);
    checks++;
    if (obs_t.size() != 0) begin errors++; $display("FAIL reset_write_ignored got %0d dispatches exp 0", obs_t.size()); end
  endtask
  task automatic test_back_to_back();
    int s;
    do_reset();
    write(8'h05, 32'hAAAA, s);
    write(8'h06, 32'hBBBB, s);
    run(5);
    checks++;
    if (obs_t.size() != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", obs_t.size()); end
    else begin
      checks += 3;
      if (obs_t[1] - obs_t[0] != 1) begin errors++; $display("FAIL b2b_gap got %0d exp 1", obs_t[1] - obs_t[0]); end
      if (obs_a[0] !== 7'h05 || obs_a[1] !== 7'h06) begin errors++; $display("FAIL b2b_addr got %h,%h exp 05,06", obs_a[0], obs_a[1]); end
      if (obs_d[0] !== 32'hAAAA || obs_d[1] !== 32'hBBBB) begin errors++; $display("FAIL b2b_data got %h,%h exp aaaa,bbbb", obs_d[0], obs_d[1]); end
    end
    raddr = 2; #1;
    checks++;
    if (rdata !== 32'd2) begin errors++; $display("FAIL b2b_disp_cnt got %0d exp 2", rdata); end
  endtask
  task automatic test_wait_spacing(input int n);
    int s;
    do_reset();
    write(8'h01, 32'h11, s);
    write(8'h80, 32'(n), s);
    write(8'h02, 32'h22, s);
    run(n + 10);
    checks++;
    if (obs_t.size() != 2) begin errors++; $display("FAIL wait%0d_count got %0d exp 2", n, obs_t.size()); end
    else begin
      checks++;
      if (obs_t[1] - obs_t[0] != n + 2) begin errors++; $display("FAIL wait%0d_gap got %0d exp %0d", n, obs_t[1] - obs_t[0], n + 2); end
    end
  endtask
  task automatic test_full();
    int s;
    do_reset();
    write(8'h80, 32'd1000, s);
    for (int i = 0; i < 17; i++) begin
      write(8'(8'h10 + i), 32'(i * 7), s);
      checks++;
      if ((i < 16 && s != 0) || (i == 16 && s == 0)) begin errors++; $display("FAIL full_stall write %0d got %0d stall cycles", i, s); end
    end
    run(40);
    checks++;
    if (obs_t.size() != 17) begin errors++; $display("FAIL full_count got %0d exp 17", obs_t.size()); end
    else for (int i = 0; i < 17; i++) begin
      checks++;
      if (obs_a[i] !== 7'(8'h10 + i) || obs_d[i] !== 32'(i * 7)) begin errors++; $display("FAIL full_order idx %0d got %h/%h exp %h/%h", i, obs_a[i], obs_d[i], 7'(8'h10 + i), 32'(i * 7)); end
    end
  endtask
  task automatic test_sync();
    int s;
    do_reset();
    write(8'h80, 32'd50, s);
    write(8'h03, 32'h33, s);
    write(8'h82, 32'h0, s);
    raddr = 0; #1;
    checks += 3;
    if (s < 50) begin errors++; $display("FAIL sync_stall got %0d exp >=50", s); end
    if (rdata[3] !== 1'b0) begin errors++; $display("FAIL sync_busy got %b exp 0", rdata[3]); end
    if (obs_t.size() != 1) begin errors++; $display("FAIL sync_dispatch got %0d exp 1", obs_t.size()); end
  endtask
  task automatic test_case_err();
    int s;
    do_reset();
    case_sel = 8'h07;
    write(8'h81, 32'h0, s);
    raddr = 4; #1;
    checks += 2;
    if (jmp !== 32'h1C) begin errors++; $display("FAIL case_jmp got %h exp 1c", jmp); end
    if (rdata !== 32'h1C) begin errors++; $display("FAIL case_read got %h exp 1c", rdata); end
    write(8'h90, 32'h55, s);
    raddr = 3; #1;
    checks++;
    if (rdata !== 32'd1) begin errors++; $display("FAIL err_cnt got %0d exp 1", rdata); end
    run(5);
    checks++;
    if (obs_t.size() != 0) begin errors++; $display("FAIL err_dispatch got %0d exp 0", obs_t.size()); end
  endtask
  task automatic test_reset_mid();
    int s;
    do_reset();
    write(8'h80, 32'd100, s);
    for (int i = 0; i < 5; i++) write(8'(8'h20 + i), 32'(i), s);
    run(3);
    i_rst = 1; step(); i_rst = 0;
    obs_t.delete(); obs_a.delete(); obs_d.delete();
    run(120);
    raddr = 0; #1;
    checks += 3;
    if (obs_t.size() != 0) begin errors++; $display("FAIL midrst_dispatch got %0d exp 0", obs_t.size()); end
    if (rdata !== 32'h2) begin errors++; $display("FAIL midrst_status got %h exp 2", rdata); end
    if (rt_addr !== 7'd0 || rt_data !== 32'd0 || jmp !== 32'd0 || hlt !== 1'b0) begin errors++; $display("FAIL midrst_outputs got %h/%h/%h/%b exp 0", rt_addr, rt_data, jmp, hlt); end
  endtask
  task automatic test_random();
    int s, k;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      raddr = 3'($urandom_range(0, 7));
      case_sel = 8'($urandom);
      if (i == 200) begin i_rst = 1; step(); i_rst = 0; end
      if (k <= 4) write(8'($urandom_range(0, 127)), $urandom, s);
      else if (k == 5) write(8'h80, 32'($urandom_range(0, 6)), s);
      else if (k == 6) write(8'h81, $urandom, s);
      else if (k == 7) write(8'h82, $urandom, s);
      else if (k == 8) write(8'($urandom_range(131, 255)), $urandom, s);
      else run($urandom_range(0, 3));
    end
    run(60);
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_wait_spacing(10);
    test_wait_spacing(0);
    test_wait_spacing(1);
    test_full();
    test_sync();
    test_case_err();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
